// File: rtl/fix_mac_acc.sv
// Accumulates TAPS sign-magnitude products plus a bias per window; emits a rounded, saturated Q7.8 result.
// Result is registered one cycle after the last tap is sampled; there is no backpressure, so every out_valid pulse must be taken.
module fix_mac_acc #(
    parameter int DATA  = 16,
    parameter int EX_SI = DATA - 1,
    parameter int POIN  = 8,
    parameter int TAPS  = 9,
    parameter int ACC_W = 40,
    parameter bit RELU  = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               in_valid,
    input  logic [EX_SI*2:0]   in_data,
    input  logic [DATA-1:0]    bias,
    output logic               out_valid,
    output logic [DATA-1:0]    out_data,
    output logic               out_ovf
);

    localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TAPS - 1);
    localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << (POIN - 1);
    localparam logic [ACC_W-1:0] MAXV = {{(ACC_W-DATA+1){1'b0}}, {(DATA-1){1'b1}}};

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic             done_q, done_d;
    logic             out_valid_q, out_valid_d;
    logic [DATA-1:0]  out_data_q, out_data_d;
    logic             out_ovf_q, out_ovf_d;

    logic [ACC_W-1:0] prod_mag, prod, bias_mag, bias_ext, base, nsum;
    logic [ACC_W-1:0] res_mag, res_rnd;
    logic             res_neg, res_sat, res_ovf;
    logic [DATA-2:0]  res_r;
    logic [DATA-1:0]  res_dat;

    // A negative-zero operand negates to zero, so it contributes nothing.
    always_comb begin
        prod_mag = ACC_W'(in_data[EX_SI*2-1:0]);
        prod     = in_data[EX_SI*2] ? -prod_mag : prod_mag;
        bias_mag = ACC_W'(bias[DATA-2:0]);
        bias_ext = (bias[DATA-1] ? -bias_mag : bias_mag) << POIN;
        base     = (cnt_q == '0) ? bias_ext : acc_q;
        nsum     = base + prod;
    end

    always_comb begin
        res_neg = sum_q[ACC_W-1];
        res_mag = res_neg ? -sum_q : sum_q;
        res_rnd = (res_mag + HALF) >> POIN;
        res_sat = res_rnd > MAXV;
        res_r   = res_sat ? {(DATA-1){1'b1}} : res_rnd[DATA-2:0];
        res_dat = {res_neg && (res_r != '0), res_r};
        res_ovf = res_sat;
        if (RELU && res_neg) begin
            res_dat = '0;
            res_ovf = 1'b0;
        end
    end

    // clr aborts the window but leaves an already captured result in flight.
    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        sum_d       = sum_q;
        done_d      = 1'b0;
        out_valid_d = done_q;
        out_data_d  = done_q ? res_dat : out_data_q;
        out_ovf_d   = done_q ? res_ovf : out_ovf_q;
        if (clr) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (in_valid) begin
            acc_d = nsum;
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                sum_d  = nsum;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_fix_mac_acc.sv
// Bench for fix_mac_acc: a RELU=0 and a RELU=1 instance share stimulus; expected results go through a scoreboard queue.
module tb_fix_mac_acc;

    localparam logic [30:0] ONE    = 31'h0001_0000;
    localparam logic [30:0] M_ONE  = 31'h4001_0000;
    localparam logic [30:0] BIG    = 31'h00C8_0000;
    localparam logic [30:0] M_BIG  = 31'h40C8_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [30:0] in_data = '0;
    logic [15:0] bias = '0;
    logic        out_valid, out_ovf, r_valid, r_ovf;
    logic [15:0] out_data, r_data;

    always #5 clk = ~clk;

    fix_mac_acc #(.RELU(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .bias(bias), .out_valid(out_valid), .out_data(out_data), .out_ovf(out_ovf)
    );

    fix_mac_acc #(.RELU(1'b1)) dut_relu (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .bias(bias), .out_valid(r_valid), .out_data(r_data), .out_ovf(r_ovf)
    );

    typedef struct {
        logic [15:0] bias;
        logic [30:0] tap0;
        logic [30:0] tapn;
        logic [15:0] exp_d;
        logic        exp_o;
        logic [15:0] rel_d;
        logic        rel_o;
    } vec_t;

    typedef struct {
        logic [15:0] d;
        logic        o;
        logic [15:0] rd;
        logic        ro;
        int          cyc;
    } exp_t;

    vec_t        tbl[9];
    exp_t        sbq[$];
    exp_t        e;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] hold_d = '0, hold_rd = '0;
    logic        hold_o = 1'b0, hold_ro = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] b, input logic [30:0] t0, input logic [30:0] tn,
                                input logic [15:0] ed, input logic eo, input logic [15:0] rd, input logic ro);
        vec_t v;
        v.bias = b; v.tap0 = t0; v.tapn = tn;
        v.exp_d = ed; v.exp_o = eo; v.rel_d = rd; v.rel_o = ro;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bias is scrambled after tap 0 so that late sampling of it would show up.
    task automatic run_window(input vec_t v, input int gmax);
        exp_t x;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_data  = (i == 0) ? v.tap0 : v.tapn;
            bias     = (i == 0) ? v.bias : 16'h7FFF;
            if (i == 8) begin
                x.d = v.exp_d; x.o = v.exp_o; x.rd = v.rel_d; x.ro = v.rel_o; x.cyc = cyc + 2;
                sbq.push_back(x);
            end
            step();
            if (gmax > 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, gmax)) step();
            end
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_d = '0; hold_o = 1'b0; hold_rd = '0; hold_ro = 1'b0;
        end else if (out_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("latency_cycle", 32'(cyc), 32'(e.cyc));
                chk("out_data", 32'(out_data), 32'(e.d));
                chk("out_ovf", 32'(out_ovf), 32'(e.o));
                chk("relu_out_valid", 32'(r_valid), 32'd1);
                chk("relu_out_data", 32'(r_data), 32'(e.rd));
                chk("relu_out_ovf", 32'(r_ovf), 32'(e.ro));
                hold_d = e.d; hold_o = e.o; hold_rd = e.rd; hold_ro = e.ro;
            end
        end else begin
            chk("hold_out_data", 32'(out_data), 32'(hold_d));
            chk("hold_out_ovf", 32'(out_ovf), 32'(hold_o));
            chk("relu_idle_valid", 32'(r_valid), 32'd0);
            chk("relu_hold_data", 32'(r_data), 32'(hold_rd));
            chk("relu_hold_ovf", 32'(r_ovf), 32'(hold_ro));
        end
    end

    initial begin
        tbl[0] = mk(16'h0000, ONE,          ONE,    16'h0900, 1'b0, 16'h0900, 1'b0);
        tbl[1] = mk(16'h0000, M_ONE,        M_ONE,  16'h8900, 1'b0, 16'h0000, 1'b0);
        tbl[2] = mk(16'h0000, 31'h0000_0080, '0,    16'h0001, 1'b0, 16'h0001, 1'b0);
        tbl[3] = mk(16'h0000, 31'h0000_007F, '0,    16'h0000, 1'b0, 16'h0000, 1'b0);
        tbl[4] = mk(16'h0000, 31'h4000_0080, '0,    16'h8001, 1'b0, 16'h0000, 1'b0);
        tbl[5] = mk(16'h0000, 31'h4000_007F, '0,    16'h0000, 1'b0, 16'h0000, 1'b0);
        tbl[6] = mk(16'h8100, ONE,          ONE,    16'h0800, 1'b0, 16'h0800, 1'b0);
        tbl[7] = mk(16'h0000, BIG,          BIG,    16'h7FFF, 1'b1, 16'h7FFF, 1'b1);
        tbl[8] = mk(16'h0000, M_BIG,        M_BIG,  16'hFFFF, 1'b1, 16'h0000, 1'b0);

        repeat (2) step();
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_out_ovf", 32'(out_ovf), 32'd0);
        chk("reset_relu_valid", 32'(r_valid), 32'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 9; i++) begin
            run_window(tbl[i], 0);
            idle(4);
        end

        run_window(tbl[0], 3);
        idle(4);
        run_window(tbl[6], 3);
        idle(4);

        run_window(tbl[0], 0);
        run_window(tbl[0], 0);
        idle(4);

        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = ONE; step();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        run_window(tbl[0], 0);
        idle(4);

        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = ONE; step();
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        run_window(tbl[0], 0);
        idle(4);

        run_window(tbl[1], 0);
        in_valid = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        idle(4);

        idle(5);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fix_mac_acc.md
# fix_mac_acc

- Accumulation stage directly downstream of the fixed-point multiplier in the conv core.
- Consumes the multiplier's sign-magnitude products (sign + 30-bit magnitude, 16 fractional bits), one per valid cycle.
- Sums TAPS products per kernel window plus a per-window bias.
- Emits one rounded, saturated Q7.8 sign-magnitude result per window for the next layer / output buffer.

## Interface

Parameters:
- DATA, 16: output / bias word width (1 sign, 7 integer, 8 fraction).
- EX_SI, DATA-1: magnitude width of an operand; product input is EX_SI*2+1 bits.
- POIN, 8: output fractional bits; product fractional bits are 2*POIN.
- TAPS, 9: products per window (≥1).
- ACC_W, 40: signed two's-complement accumulator width; must hold TAPS·2^(2*EX_SI) plus the bias without wrap.
- RELU, 0: when 1, negative results are output as 0.

Ports:
- clk, in, 1: single clock, all logic on rising edge.
- rst_n, in, 1: reset, synchronous, active-low.
- clr, in, 1: synchronous window abort.
- in_valid, in, 1: in_data holds a product this cycle.
- in_data, in, EX_SI*2+1: [EX_SI*2] sign, [EX_SI*2-1:0] unsigned magnitude, 2*POIN fractional bits.
- bias, in, DATA: Q7.8 sign-magnitude bias, sampled with the first tap of each window.
- out_valid, out, 1: one-cycle pulse, result valid.
- out_data, out, DATA: Q7.8 sign-magnitude result.
- out_ovf, out, 1: result saturated; qualified by out_valid.

## Operation

- **Tap counter** `cnt`, 0..TAPS-1:
  - Increments on each accepted in_valid.
  - Wraps to 0 after TAPS-1.
  - Holds when in_valid=0; gaps between taps are legal.
- **Product conversion:** magnitude zero-extended to ACC_W and negated if sign=1. A magnitude of 0 with sign=1 contributes 0.
- **Accumulate:**
  - cnt==0: acc <= bias_ext + p, where bias_ext is the bias converted the same way and shifted left by POIN.
  - Otherwise: acc <= acc + p.
- **Window end:** when cnt==TAPS-1 and in_valid, the final sum (acc+p) is captured into a result register and `done` is set for one cycle.
- **Output stage:** runs on the cycle after done.
  - m = |sum|
  - r = (m + 2^(POIN-1)) >> POIN, i.e. round half away from zero.
  - If r > 2^(DATA-1)-1: r = 2^(DATA-1)-1 and out_ovf=1.
  - Sign bit = (sum<0) && r≠0, so -0 is never emitted.
  - RELU=1 and sum<0: out_data=0, out_ovf=0.
- **Back-to-back windows:** the tap after the last tap is tap 0 of the next window, with no bubble. A new window may accumulate while the previous result is in the output stage.
- **clr:**
  - Forces cnt=0 and acc=0.
  - Overrides in_valid in the same cycle; that sample is dropped.
  - Does not cancel a result already captured (done=1); that result is still emitted.
- **No backpressure:** the downstream stage must accept every out_valid pulse.

## Timing

- **Reset** (rst_n=0 at a rising edge): cnt=0, acc=0, done=0, out_valid=0, out_data=0, out_ovf=0. Any partial window and any in-flight result are discarded.
- **Latency:**
  - Last tap sampled at edge E → done set at E.
  - out_valid, out_data and out_ovf are registered at E+1, high for exactly one cycle.
  - Downstream samples them at E+2.
- **Throughput:** one product per cycle; one result per TAPS cycles under continuous in_valid.
- **Hold:** out_data and out_ovf hold their last value while out_valid=0.
- **TAPS=1:** every accepted sample is both first and last tap (bias + p); results are emitted every cycle.
- **Upstream alignment:** in_valid must be aligned to the multiplier's 3-cycle latency. This is the responsibility of upstream control; the block does not check it.

## Test plan

- **Plain window:** TAPS=9, bias=0, nine taps of in_data = {0, 65536} (1.0) → single out_valid, out_data=0x0900, out_ovf=0. Repeat with sign=1 → out_data=0x8900.
- **Rounding:**
  - Tap0 magnitude 0x80, remaining taps 0 → out_data=0x0001.
  - Tap0 magnitude 0x7F → 0x0000.
  - Tap0 = {1, 0x80} → 0x8001.
  - Tap0 = {1, 0x7F} → 0x0000 (no -0).
- **Bias and saturation:**
  - bias=0x8100 (-1.0) with nine taps of 1.0 → 0x0800.
  - Nine taps of {0, 200<<16} → out_data=0x7FFF, out_ovf=1.
  - Same taps with sign=1 and RELU=0 → 0xFFFF, out_ovf=1.
- **Gaps and back-to-back:**
  - Nine taps with random 0–3 cycle in_valid gaps → out_valid exactly 2 edges after the last tap.
  - 18 continuous taps of 1.0 → two pulses 9 cycles apart, both 0x0900.
- **Reset / clr mid-window:**
  - 4 taps, then rst_n=0 for one cycle, then nine taps of 1.0 → only one out_valid, 0x0900.
  - Same sequence with clr instead of rst_n → same result.
  - clr asserted in the cycle after the last tap → the prior result is still emitted.
- **RELU:** RELU=1, nine taps of -1.0 → out_data=0x0000, out_ovf=0, out_valid pulses.
